// File: rtl/ram_req_ctrl_pkg.sv
// rtl/ram_req_ctrl_pkg.sv - shared types, defaults and width helpers for the SRAM request front-end
package ram_req_ctrl_pkg;

    localparam int ADDR_WIDTH_DEF = 9;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_WMASKS_DEF = 4;
    localparam int MEMD_DEF       = 512;
    localparam int RD_LATENCY_DEF = 2;
    localparam int RSP_DEPTH_DEF  = 2;

    typedef struct packed {
        logic valid;
        logic err;
    } inflight_t;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Bits needed to index n entries; never zero.
    function automatic int ptr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// rtl/ram_rsp_fifo.sv - small response FIFO with registered head outputs
module ram_rsp_fifo
    import ram_req_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_nxt;
    logic [PW-1:0]    wr_nxt;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             do_pop;
    logic [WIDTH-1:0] head_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_pop    = pop && (count != '0);
        rd_nxt    = do_pop ? ptr_inc(rd_ptr) : rd_ptr;
        wr_nxt    = push ? ptr_inc(wr_ptr) : wr_ptr;
        count_nxt = count;
        if (push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (!push && do_pop) begin
            count_nxt = count - CW'(1);
        end
        // The head register is loaded with whatever will sit at rd_nxt after this edge;
        // when that slot is the one being written now, bypass the array.
        if (count_nxt == '0) begin
            head_nxt = '0;
        end else if (push && (rd_nxt == wr_ptr)) begin
            head_nxt = push_data;
        end else begin
            head_nxt = mem[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            rd_ptr     <= rd_nxt;
            wr_ptr     <= wr_nxt;
            count      <= count_nxt;
            head_valid <= (count_nxt != '0);
            head_data  <= head_nxt;
        end
    end

    a_no_push_on_full: assert property (@(posedge clk) disable iff (rst)
        !(push && !do_pop && (count == FULL_CNT)));

endmodule

// File: rtl/ram_req_ctrl.sv
// rtl/ram_req_ctrl.sv - core load/store front-end for the banked 1rw SRAM wrapper, port 0
module ram_req_ctrl
    import ram_req_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_WMASKS = NUM_WMASKS_DEF,
    parameter int MEMD       = MEMD_DEF,
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int RSP_DEPTH  = RSP_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  ram_csb,
    output logic                  ram_web,
    output logic [NUM_WMASKS-1:0] ram_wmask,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int CW = cnt_width(RSP_DEPTH);
    localparam logic [CW-1:0]         CREDIT_MAX = CW'(RSP_DEPTH);
    localparam logic [ADDR_WIDTH:0]   MEMD_LIM   = (ADDR_WIDTH + 1)'(MEMD);

    generate
        if (RD_LATENCY < 1 || RSP_DEPTH < 1 || MEMD < 1 || MEMD > (1 << ADDR_WIDTH)
            || NUM_WMASKS * 8 != DATA_WIDTH) begin : g_bad_params
            $error("ram_req_ctrl: illegal parameter combination");
        end
    endgenerate

    logic                         in_range;
    logic                         fire;
    logic                         load_fire;
    logic                         pop;
    logic [CW-1:0]                credits;
    inflight_t [RD_LATENCY-1:0]   pipe;
    logic                         fifo_push;
    logic [DATA_WIDTH:0]          fifo_din;
    logic                         fifo_valid;
    logic [DATA_WIDTH:0]          fifo_dout;

    assign in_range  = ({1'b0, req_addr} < MEMD_LIM);
    // Stores never need a credit; loads wait until the FIFO is guaranteed room.
    assign req_ready = !rst && (req_we || (credits != '0));
    assign fire      = req_valid && req_ready;
    assign load_fire = fire && !req_we;

    assign ram_csb   = !(fire && in_range);
    assign ram_web   = !(fire && req_we);
    assign ram_wmask = fire ? req_wmask : '0;
    assign ram_addr  = req_addr;
    assign ram_din   = req_wdata;

    // Out-of-range loads still travel the pipe so responses stay in issue order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= inflight_t'{valid: load_fire, err: !in_range};
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign fifo_push = pipe[RD_LATENCY-1].valid;
    assign fifo_din  = pipe[RD_LATENCY-1].err ? {1'b1, {DATA_WIDTH{1'b0}}} : {1'b0, ram_dout};
    assign pop       = fifo_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= CREDIT_MAX;
        end else if (load_fire && !pop) begin
            credits <= credits - CW'(1);
        end else if (!load_fire && pop) begin
            credits <= credits + CW'(1);
        end
    end

    a_credit_underflow: assert property (@(posedge clk) disable iff (rst)
        !(load_fire && !pop && (credits == '0)));
    a_credit_overflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && !load_fire && (credits == CREDIT_MAX)));

    ram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_data  (fifo_din),
        .pop        (pop),
        .head_valid (fifo_valid),
        .head_data  (fifo_dout)
    );

    assign rsp_valid = fifo_valid;
    assign rsp_rdata = fifo_dout[DATA_WIDTH-1:0];
    assign rsp_err   = fifo_dout[DATA_WIDTH];

endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb/tb_ram_req_ctrl.sv - randomized self-checking bench for ram_req_ctrl with a queue-based reference
module tb_ram_req_ctrl;

    localparam int AW   = 9;
    localparam int DW   = 32;
    localparam int NW   = 4;
    localparam int MEMD = 300;
    localparam int RDL  = 2;
    localparam int RD   = 2;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [NW-1:0] req_wmask;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          ram_csb;
    logic          ram_web;
    logic [NW-1:0] ram_wmask;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    ram_req_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WMASKS (NW),
        .MEMD       (MEMD),
        .RD_LATENCY (RDL),
        .RSP_DEPTH  (RD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_wmask (req_wmask),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_csb   (ram_csb),
        .ram_web   (ram_web),
        .ram_wmask (ram_wmask),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM wrapper: read data sampled by the controller RDL edges after the read edge.
    logic [DW-1:0] ram_mem [1 << AW];
    logic [DW-1:0] rpipe   [RDL];
    assign ram_dout = rpipe[RDL-1];

    always @(posedge clk) begin
        for (int i = RDL - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
        rpipe[0] <= $urandom;
        if (!ram_csb) begin
            if (!ram_web) begin
                for (int b = 0; b < NW; b++)
                    if (ram_wmask[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                rpipe[0] <= ram_mem[ram_addr];
            end
        end
    end

    // Reference: outstanding loads in issue order, each visible from a fixed cycle onward.
    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            due;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] shadow [1 << AW];
    int            cyc = 0;
    int            n_pops = 0;
    int            total = 0;
    int            bad = 0;
    logic          started = 1'b0;
    logic          m_f, m_p, m_inr;
    logic          c_f, c_inr;

    function automatic logic m_ready();
        return !rst && (req_we || (exp_q.size() < RD));
    endfunction

    function automatic logic m_valid();
        return (exp_q.size() != 0) && (exp_q[0].due <= cyc);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        m_f   = req_valid && m_ready();
        m_p   = rsp_ready && m_valid();
        m_inr = (int'(req_addr) < MEMD);
        if (rst) begin
            exp_q.delete();
        end else begin
            if (m_p) begin
                void'(exp_q.pop_front());
                n_pops++;
            end
            if (m_f && req_we && m_inr)
                for (int b = 0; b < NW; b++)
                    if (req_wmask[b]) shadow[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
            if (m_f && !req_we)
                exp_q.push_back('{m_inr ? shadow[req_addr] : '0, !m_inr, cyc + RDL + 1});
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (started) begin
            c_f   = req_valid && m_ready();
            c_inr = (int'(req_addr) < MEMD);
            chk("req_ready", req_ready, m_ready());
            chk("ram_csb", ram_csb, !(c_f && c_inr));
            chk("ram_web", ram_web, !(c_f && req_we));
            chk("ram_wmask", ram_wmask, c_f ? req_wmask : '0);
            chk("ram_addr", ram_addr, req_addr);
            chk("ram_din", ram_din, req_wdata);
            chk("rsp_valid", rsp_valid, m_valid());
            if (m_valid()) begin
                chk("rsp_rdata", rsp_rdata, exp_q[0].data);
                chk("rsp_err", rsp_err, exp_q[0].err);
            end
        end
    end

    task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [NW-1:0] m, output int fc);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        fc = -1;
        for (int i = 0; i < 60 && fc < 0; i++) begin
            @(negedge clk);
            if (m_ready()) fc = cyc;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        chk("req_accept", fc >= 0, 1);
    endtask

    task automatic wait_rsp(input int fc, input logic [DW-1:0] ed, input logic ee, input string nm);
        int seen;
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                chk({nm, "_data"}, rsp_rdata, ed);
                chk({nm, "_err"}, rsp_err, ee);
                chk({nm, "_lat"}, cyc - fc, RDL + 1);
            end
        end
        chk({nm, "_seen"}, seen, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int            fc, fc2, nacc, got_n, pops0, ncyc;
    logic [DW-1:0] got [4];
    logic [DW-1:0] saved;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            saved      = $urandom;
            ram_mem[i] = saved;
            shadow[i]  = saved;
        end
        for (int i = 0; i < RDL; i++) rpipe[i] = '0;
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h005;
        req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;

        @(posedge clk);
        started = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_ram_csb", ram_csb, 1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_rsp_rdata", rsp_rdata, 0);
        chk("post_rst_rsp_err", rsp_err, 0);
        chk("post_rst_req_ready", req_ready, 1);
        @(posedge clk);
        #1;

        do_req(1, 9'h005, 32'hDEADBEEF, 4'hF, fc);
        do_req(0, 9'h005, 32'h0, 4'h0, fc);
        wait_rsp(fc, 32'hDEADBEEF, 0, "st_ld");

        do_req(1, 9'h040, 32'h11223344, 4'hF, fc);
        do_req(1, 9'h040, 32'hAABBCCDD, 4'b0101, fc);
        do_req(0, 9'h040, 32'h0, 4'h0, fc);
        wait_rsp(fc, 32'h11BB33DD, 0, "bytemask");

        for (int i = 0; i < 4; i++) do_req(1, AW'(16 + i), 32'hA0000010 + DW'(i), 4'hF, fc);
        rsp_ready = 1'b0;
        do_req(0, 9'h010, 32'h0, 4'h0, fc);
        do_req(0, 9'h011, 32'h0, 4'h0, fc);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h012;
        nacc = 0;
        repeat (6) begin
            @(negedge clk);
            if (req_ready) nacc++;
        end
        chk("bp_accepts_while_full", nacc, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        pops0 = n_pops;
        got_n = 0;
        fork
            begin
                for (int i = 0; i < 80 && got_n < 4; i++) begin
                    @(negedge clk);
                    if (rsp_valid && rsp_ready) begin
                        got[got_n] = rsp_rdata;
                        got_n++;
                    end
                end
            end
            begin
                do_req(0, 9'h012, 32'h0, 4'h0, fc);
                do_req(0, 9'h013, 32'h0, 4'h0, fc);
            end
        join
        chk("bp_rsp_count", got_n, 4);
        for (int i = 0; i < 4; i++) chk("bp_order", got[i], 32'hA0000010 + DW'(i));
        idle(2);
        chk("bp_model_pops", n_pops - pops0, 4);

        do_req(1, 9'd299, 32'h12345678, 4'hF, fc);
        do_req(0, 9'd299, 32'h0, 4'h0, fc);
        wait_rsp(fc, 32'h12345678, 0, "last_in_range");
        do_req(0, 9'd300, 32'h0, 4'h0, fc);
        wait_rsp(fc, 32'h0, 1, "first_oor");
        do_req(0, 9'h1F0, 32'h0, 4'h0, fc);
        wait_rsp(fc, 32'h0, 1, "oor_load");
        saved = ram_mem[9'h1F0];
        do_req(1, 9'h1F0, ~saved, 4'hF, fc);
        idle(2);
        chk("oor_store_no_write", ram_mem[9'h1F0], saved);

        do_req(0, 9'h005, 32'h0, 4'h0, fc);
        do_req(0, 9'h040, 32'h0, 4'h0, fc);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        nacc = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) nacc++;
        end
        chk("midrst_no_rsp", nacc, 0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        do_req(0, 9'h005, 32'h0, 4'h0, fc);
        do_req(0, 9'h040, 32'h0, 4'h0, fc2);
        chk("midrst_credits", fc2 - fc, 1);
        rsp_ready = 1'b1;
        wait_rsp(fc, 32'hDEADBEEF, 0, "midrst_ld0");
        wait_rsp(fc2, 32'h11BB33DD, 0, "midrst_ld1");

        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom % 3) != 0;
            req_we    = $urandom % 2;
            req_addr  = (($urandom % 8) == 0) ? AW'($urandom_range(280, 511)) : AW'($urandom % 32);
            req_wdata = $urandom;
            req_wmask = NW'($urandom);
            rsp_ready = ($urandom % 4) != 0;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        ncyc = 0;
        while (exp_q.size() != 0 && ncyc < 50) begin
            @(posedge clk);
            #1;
            ncyc++;
        end
        chk("drain_empty", exp_q.size(), 0);
        @(negedge clk);
        chk("drain_rsp_valid", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
